// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encodings, pc_sel codes and stage-control bundle
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_HALT     = 2'b10
  } ctrl_state_e;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;
  localparam logic [1:0] PCSEL_JMP = 2'b10;

  typedef struct packed {
    logic       pc_we;
    logic       ifid_we;
    logic       idex_we;
    logic       exmem_we;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_flush;
    logic [1:0] pc_sel;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_RUN  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, PCSEL_SEQ};
  localparam stage_ctrl_t CTRL_IDLE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, PCSEL_SEQ};
  localparam stage_ctrl_t CTRL_RST  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, PCSEL_SEQ};

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard inputs and stage-control outputs between controller and pipeline
interface pipe_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       ex_mem_read;
  logic [4:0] ex_rt;
  logic       mem_branch;
  logic       mem_zf;
  logic       mem_jump;
  logic       mem_req;
  logic       mem_ready;
  logic       pc_we;
  logic       ifid_we;
  logic       idex_we;
  logic       exmem_we;
  logic       ifid_flush;
  logic       idex_flush;
  logic       exmem_flush;
  logic [1:0] pc_sel;

  modport master (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
    input  mem_branch, mem_zf, mem_jump, mem_req, mem_ready,
    output pc_we, ifid_we, idex_we, exmem_we,
    output ifid_flush, idex_flush, exmem_flush, pc_sel
  );

  modport slave (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
    output mem_branch, mem_zf, mem_jump, mem_req, mem_ready,
    input  pc_we, ifid_we, idex_we, exmem_we,
    input  ifid_flush, idex_flush, exmem_flush, pc_sel
  );
endinterface

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use hazard compare between ID/EX load and IF/ID sources
module hazard_detect (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  output logic       load_use
);

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush/redirect controller with memory-wait timeout and perf counters
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_if.master      pif,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  ctrl_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  logic        load_use;
  logic        redirect;
  logic        run_active;
  stage_ctrl_t run_ctl;
  stage_ctrl_t ctl;

  hazard_detect u_hazard (
    .id_rs       (pif.id_rs),
    .id_rt       (pif.id_rt),
    .id_uses_rt  (pif.id_uses_rt),
    .ex_mem_read (pif.ex_mem_read),
    .ex_rt       (pif.ex_rt),
    .load_use    (load_use)
  );

  assign redirect = (pif.mem_branch && pif.mem_zf) || pif.mem_jump;

  // What RUN drives when no memory wait applies; MEM_WAIT reuses it on release
  always_comb begin
    run_ctl = CTRL_RUN;
    if (redirect) begin
      run_ctl.ifid_flush  = 1'b1;
      run_ctl.idex_flush  = 1'b1;
      run_ctl.exmem_flush = 1'b1;
      run_ctl.pc_sel      = pif.mem_jump ? PCSEL_JMP : PCSEL_BR;
    end else if (load_use) begin
      run_ctl.pc_we      = 1'b0;
      run_ctl.ifid_we    = 1'b0;
      run_ctl.idex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ctl        = CTRL_IDLE;
    run_active = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (pif.mem_req && !pif.mem_ready) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
        end else begin
          ctl        = run_ctl;
          run_active = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (pif.mem_ready) begin
          ctl        = run_ctl;
          run_active = 1'b1;
          state_d    = ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    if (rst) begin
      ctl        = CTRL_RST;
      run_active = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!rst && (state_q != ST_HALT) && !ctl.pc_we && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (run_active && redirect && (flush_q != CNT_MAX)) begin
      flush_d = flush_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign pif.pc_we       = ctl.pc_we;
  assign pif.ifid_we     = ctl.ifid_we;
  assign pif.idex_we     = ctl.idex_we;
  assign pif.exmem_we    = ctl.exmem_we;
  assign pif.ifid_flush  = ctl.ifid_flush;
  assign pif.idex_flush  = ctl.idex_flush;
  assign pif.exmem_flush = ctl.exmem_flush;
  assign pif.pc_sel      = ctl.pc_sel;

  assign halted       = (state_q == ST_HALT);
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        halted, halted_s;
  logic [15:0] stall_cycles, flush_events;
  logic [3:0]  stall_s, flush_s;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_stall, exp_flush;

  // packed order: pc_we ifid_we idex_we exmem_we | ifid_fl idex_fl exmem_fl | pc_sel
  localparam logic [8:0] C_RUN  = 9'b1111_000_00;
  localparam logic [8:0] C_IDLE = 9'b0000_000_00;
  localparam logic [8:0] C_RST  = 9'b0000_111_00;
  localparam logic [8:0] C_LU   = 9'b0011_010_00;
  localparam logic [8:0] C_BR   = 9'b1111_111_01;
  localparam logic [8:0] C_JMP  = 9'b1111_111_10;

  pipe_ctrl_if pif ();
  pipe_ctrl_if pif_s ();

  logic [8:0] ctl_obs;
  assign ctl_obs = {pif.pc_we, pif.ifid_we, pif.idex_we, pif.exmem_we,
                    pif.ifid_flush, pif.idex_flush, pif.exmem_flush, pif.pc_sel};

  assign pif_s.id_rs       = pif.id_rs;
  assign pif_s.id_rt       = pif.id_rt;
  assign pif_s.id_uses_rt  = pif.id_uses_rt;
  assign pif_s.ex_mem_read = pif.ex_mem_read;
  assign pif_s.ex_rt       = pif.ex_rt;
  assign pif_s.mem_branch  = pif.mem_branch;
  assign pif_s.mem_zf      = pif.mem_zf;
  assign pif_s.mem_jump    = pif.mem_jump;
  assign pif_s.mem_req     = pif.mem_req;
  assign pif_s.mem_ready   = pif.mem_ready;

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .pif          (pif),
    .halted       (halted),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  pipeline_ctrl #(.MEM_TIMEOUT(16), .CNT_W(4)) u_dut_small (
    .clk          (clk),
    .rst          (rst),
    .pif          (pif_s),
    .halted       (halted_s),
    .stall_cycles (stall_s),
    .flush_events (flush_s)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pif.id_rs = 5'd0; pif.id_rt = 5'd0; pif.id_uses_rt = 1'b0;
    pif.ex_mem_read = 1'b0; pif.ex_rt = 5'd0;
    pif.mem_branch = 1'b0; pif.mem_zf = 1'b0; pif.mem_jump = 1'b0;
    pif.mem_req = 1'b0; pif.mem_ready = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] ert, input logic [4:0] rs,
                              input logic [4:0] rt, input logic urt);
    pif.ex_mem_read = 1'b1; pif.ex_rt = ert;
    pif.id_rs = rs; pif.id_rt = rt; pif.id_uses_rt = urt;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    n_checks++;
    if (ctl_obs !== C_RST) begin n_fail++; $display("FAIL rst_ctl: got %b want %b", ctl_obs, C_RST); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (ctl_obs !== C_RUN) begin n_fail++; $display("FAIL rst_run_ctl: got %b want %b", ctl_obs, C_RUN); end
    n_checks++;
    if ({halted, stall_cycles, flush_events} !== 33'd0)
      begin n_fail++; $display("FAIL rst_state: got h=%b s=%0d f=%0d want 0/0/0", halted, stall_cycles, flush_events); end
    exp_stall = 0;
    exp_flush = 0;
  endtask

  task automatic test_load_use();
    set_load_use(5'd8, 5'd8, 5'd0, 1'b0);
    #1;
    n_checks++;
    if (ctl_obs !== C_LU) begin n_fail++; $display("FAIL lu_rs_ctl: got %b want %b", ctl_obs, C_LU); end
    step(); exp_stall++;
    idle_inputs();
    #1;
    n_checks++;
    if (ctl_obs !== C_RUN) begin n_fail++; $display("FAIL lu_one_bubble: got %b want %b", ctl_obs, C_RUN); end
    n_checks++;
    if (stall_cycles !== 16'(exp_stall)) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d want %0d", stall_cycles, exp_stall); end
    set_load_use(5'd5, 5'd3, 5'd5, 1'b1);
    #1;
    n_checks++;
    if (ctl_obs !== C_LU) begin n_fail++; $display("FAIL lu_rt_ctl: got %b want %b", ctl_obs, C_LU); end
    step(); exp_stall++;
    set_load_use(5'd5, 5'd3, 5'd5, 1'b0);
    #1;
    n_checks++;
    if (ctl_obs !== C_RUN) begin n_fail++; $display("FAIL lu_rt_unused: got %b want %b", ctl_obs, C_RUN); end
    step();
    set_load_use(5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    n_checks++;
    if (ctl_obs !== C_RUN) begin n_fail++; $display("FAIL lu_r0: got %b want %b", ctl_obs, C_RUN); end
    step();
    idle_inputs();
    n_checks++;
    if (stall_cycles !== 16'(exp_stall)) begin n_fail++; $display("FAIL lu_stall_total: got %0d want %0d", stall_cycles, exp_stall); end
  endtask

  task automatic test_redirect();
    pif.mem_branch = 1'b1; pif.mem_zf = 1'b1;
    #1;
    n_checks++;
    if (ctl_obs !== C_BR) begin n_fail++; $display("FAIL br_taken_ctl: got %b want %b", ctl_obs, C_BR); end
    step(); exp_flush++;
    pif.mem_zf = 1'b0;
    #1;
    n_checks++;
    if (ctl_obs !== C_RUN) begin n_fail++; $display("FAIL br_not_taken: got %b want %b", ctl_obs, C_RUN); end
    n_checks++;
    if (flush_events !== 16'(exp_flush)) begin n_fail++; $display("FAIL br_flush_cnt: got %0d want %0d", flush_events, exp_flush); end
    step();
    pif.mem_zf = 1'b1; pif.mem_jump = 1'b1;
    #1;
    n_checks++;
    if (ctl_obs !== C_JMP) begin n_fail++; $display("FAIL jmp_wins: got %b want %b", ctl_obs, C_JMP); end
    step(); exp_flush++;
    pif.mem_branch = 1'b0; pif.mem_zf = 1'b0;
    set_load_use(5'd9, 5'd9, 5'd0, 1'b0);
    #1;
    n_checks++;
    if (ctl_obs !== C_JMP) begin n_fail++; $display("FAIL jmp_over_lu: got %b want %b", ctl_obs, C_JMP); end
    step(); exp_flush++;
    idle_inputs();
    #1;
    n_checks++;
    if ({stall_cycles, flush_events} !== {16'(exp_stall), 16'(exp_flush)})
      begin n_fail++; $display("FAIL redir_cnts: got s=%0d f=%0d want s=%0d f=%0d", stall_cycles, flush_events, exp_stall, exp_flush); end
  endtask

  task automatic test_mem_wait();
    pif.mem_req = 1'b1; pif.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (ctl_obs !== C_IDLE) begin n_fail++; $display("FAIL mw_stall_c%0d: got %b want %b", i, ctl_obs, C_IDLE); end
      step(); exp_stall++;
    end
    pif.mem_ready = 1'b1; pif.mem_branch = 1'b1; pif.mem_zf = 1'b1;
    #1;
    n_checks++;
    if (ctl_obs !== C_BR) begin n_fail++; $display("FAIL mw_release: got %b want %b", ctl_obs, C_BR); end
    step(); exp_flush++;
    idle_inputs();
    #1;
    n_checks++;
    if (ctl_obs !== C_RUN) begin n_fail++; $display("FAIL mw_back_run: got %b want %b", ctl_obs, C_RUN); end
    n_checks++;
    if ({stall_cycles, flush_events} !== {16'(exp_stall), 16'(exp_flush)})
      begin n_fail++; $display("FAIL mw_cnts: got s=%0d f=%0d want s=%0d f=%0d", stall_cycles, flush_events, exp_stall, exp_flush); end
  endtask

  task automatic test_timeout_boundary();
    pif.mem_req = 1'b1; pif.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin step(); exp_stall++; end
    pif.mem_ready = 1'b1;
    #1;
    n_checks++;
    if (ctl_obs !== C_RUN) begin n_fail++; $display("FAIL tob_ready_wins: got %b want %b", ctl_obs, C_RUN); end
    step();
    idle_inputs();
    #1;
    n_checks++;
    if ({halted, ctl_obs} !== {1'b0, C_RUN}) begin n_fail++; $display("FAIL tob_not_halted: got h=%b %b want h=0 %b", halted, ctl_obs, C_RUN); end
  endtask

  task automatic test_timeout();
    pif.mem_req = 1'b1; pif.mem_ready = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({halted, stall_cycles, flush_events, ctl_obs} !== {33'd0, C_IDLE})
      begin n_fail++; $display("FAIL rst_mid_wait: got h=%b s=%0d f=%0d %b", halted, stall_cycles, flush_events, ctl_obs); end
    exp_stall = 0;
    exp_flush = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i <= 5) exp_stall++;
      n_checks++;
      if (halted !== (i >= 5)) begin n_fail++; $display("FAIL to_halt_e%0d: got %b want %b", i, halted, (i >= 5)); end
    end
    pif.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({halted, ctl_obs} !== {1'b1, C_IDLE}) begin n_fail++; $display("FAIL halt_sticky_%0d: got h=%b %b want h=1 %b", i, halted, ctl_obs, C_IDLE); end
    end
    n_checks++;
    if (stall_cycles !== 16'(exp_stall)) begin n_fail++; $display("FAIL to_stall_cnt: got %0d want %0d", stall_cycles, exp_stall); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (ctl_obs !== C_RST) begin n_fail++; $display("FAIL halt_rst_ctl: got %b want %b", ctl_obs, C_RST); end
    step();
    rst = 1'b0;
    idle_inputs();
    #1;
    n_checks++;
    if ({halted, stall_cycles, ctl_obs} !== {17'd0, C_RUN})
      begin n_fail++; $display("FAIL halt_cleared: got h=%b s=%0d %b want h=0 s=0 %b", halted, stall_cycles, ctl_obs, C_RUN); end
    exp_stall = 0;
  endtask

  task automatic test_priority();
    pif.mem_req = 1'b1; pif.mem_ready = 1'b0;
    pif.mem_branch = 1'b1; pif.mem_zf = 1'b1;
    set_load_use(5'd7, 5'd7, 5'd0, 1'b0);
    #1;
    n_checks++;
    if (ctl_obs !== C_IDLE) begin n_fail++; $display("FAIL prio_memwait: got %b want %b", ctl_obs, C_IDLE); end
    step(); exp_stall++;
    pif.mem_ready = 1'b1;
    #1;
    n_checks++;
    if (ctl_obs !== C_BR) begin n_fail++; $display("FAIL prio_release_br: got %b want %b", ctl_obs, C_BR); end
    step(); exp_flush++;
    idle_inputs();
    n_checks++;
    if ({stall_cycles, flush_events} !== {16'(exp_stall), 16'(exp_flush)})
      begin n_fail++; $display("FAIL prio_cnts: got s=%0d f=%0d want s=%0d f=%0d", stall_cycles, flush_events, exp_stall, exp_flush); end
  endtask

  task automatic test_saturation();
    set_load_use(5'd4, 5'd4, 5'd0, 1'b0);
    for (int i = 0; i < 65540; i++) step();
    n_checks++;
    if (stall_cycles !== 16'hFFFF) begin n_fail++; $display("FAIL sat_stall16: got %h want ffff", stall_cycles); end
    n_checks++;
    if (stall_s !== 4'hF) begin n_fail++; $display("FAIL sat_stall4: got %h want f", stall_s); end
    idle_inputs();
    pif.mem_jump = 1'b1;
    for (int i = 0; i < 20; i++) begin step(); exp_flush++; end
    n_checks++;
    if (flush_s !== 4'hF) begin n_fail++; $display("FAIL sat_flush4: got %h want f", flush_s); end
    n_checks++;
    if ({stall_cycles, flush_events} !== {16'hFFFF, 16'(exp_flush)})
      begin n_fail++; $display("FAIL sat_hold: got s=%h f=%0d want s=ffff f=%0d", stall_cycles, flush_events, exp_flush); end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout_boundary();
    test_timeout();
    test_priority();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
